// File: rtl/apb_csr_pkg.sv
// Shared types and helpers for the APB CSR completer and any peripheral-specific
// completers built on the same decode.
package apb_csr_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } csr_state_e;

    localparam int ADDR_LSB   = 2;
    localparam int MAX_DATA_W = 256;

    // Callers zero-extend narrower buses into the MAX_DATA_W-wide operands.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0]   old_v,
        input logic [MAX_DATA_W-1:0]   new_v,
        input logic [MAX_DATA_W/8-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < MAX_DATA_W/8; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_csr_if.sv
// APB4 bus bundle between the SoC fabric (master) and a CSR completer (slave).
interface apb_csr_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                pwrite;
    logic                psel;
    logic                penable;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pstrb, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pstrb, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_csr_decode.sv
// Combinational address decode: register index plus bad-access flag
// (misaligned, out of range, or write to a read-only register).
module apb_csr_decode
    import apb_csr_pkg::*;
#(
    parameter int                  ADDR_W   = 12,
    parameter int                  NUM_REGS = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic [ADDR_W-1:0]          paddr,
    input  logic                       pwrite,
    output logic [ADDR_W-ADDR_LSB-1:0] index,
    output logic                       err
);
    logic misaligned;
    logic out_of_range;
    logic ro_hit;

    assign index        = paddr[ADDR_W-1:ADDR_LSB];
    assign misaligned   = |paddr[ADDR_LSB-1:0];
    assign out_of_range = int'(index) >= NUM_REGS;

    always_comb begin
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(index) == i) ro_hit = RO_MASK[i];
        end
    end

    assign err = misaligned | out_of_range | (pwrite & ro_hit);
endmodule

// File: rtl/apb_csr_completer.sv
// APB4 completer owning NUM_REGS x DATA_W CSRs; wait states are enabled with APB_CSR_WAIT_EN.
//   state  | meaning
//   IDLE   | waiting for a setup phase (psel & ~penable)
//   ACCESS | transfer captured; completes when psel & penable & wait count expired
module apb_csr_completer
    import apb_csr_pkg::*;
#(
    parameter int                  ADDR_W      = 12,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RST_VAL     = '0,
    parameter int                  WAIT_STATES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    apb_csr_if.slave                     apb,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_rd,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int IDX_W  = ADDR_W - ADDR_LSB;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    csr_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, dec_idx;
    logic                pwrite_q, pwrite_d;
    logic                err_q, err_d, dec_err;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [DATA_W-1:0]   reg_sel, rd_val, merged;
    logic                wait_done;
    logic                pready;

`ifdef APB_CSR_WAIT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    assign wait_done = (wait_cnt_q == 4'd0);
`else
    logic [3:0] unused_wait_load;
    assign unused_wait_load = WAIT_LOAD;
    assign wait_done = 1'b1;
`endif

    apb_csr_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_decode (
        .paddr  (apb.paddr),
        .pwrite (apb.pwrite),
        .index  (dec_idx),
        .err    (dec_err)
    );

    assign pready = (state_q == ACCESS) & apb.psel & apb.penable & wait_done;

    always_comb begin
        reg_sel = '0;
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx_q) == i) begin
                reg_sel = regs_q[i];
                rd_val  = RO_MASK[i] ? hw_rd[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    assign merged = DATA_W'(byte_merge(MAX_DATA_W'(reg_sel), MAX_DATA_W'(wdata_q),
                                       (MAX_DATA_W/8)'(strb_q)));

    assign apb.pready  = pready;
    assign apb.pslverr = pready & err_q;
    assign apb.prdata  = (pready & ~err_q & ~pwrite_q) ? rd_val : '0;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pwrite_d   = pwrite_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
`ifdef APB_CSR_WAIT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d  = ACCESS;
                    idx_d    = dec_idx;
                    pwrite_d = apb.pwrite;
                    strb_d   = apb.pstrb;
                    wdata_d  = apb.pwdata;
                    err_d    = dec_err;
`ifdef APB_CSR_WAIT_EN
                    wait_cnt_d = WAIT_LOAD;
`endif
                end
            end
            ACCESS: begin
                // Losing psel before completion abandons the transfer without side effects.
                if (!apb.psel) begin
                    state_d = IDLE;
                end else if (pready) begin
                    state_d = IDLE;
                    if (pwrite_q && !err_q && (|strb_q)) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (int'(idx_q) == i) begin
                                regs_d[i]     = merged;
                                wr_pulse_d[i] = 1'b1;
                            end
                        end
                    end
                end
`ifdef APB_CSR_WAIT_EN
                else if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pwrite_q   <= 1'b0;
            strb_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
`ifdef APB_CSR_WAIT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pwrite_q   <= pwrite_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef APB_CSR_WAIT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign wr_pulse = wr_pulse_q;
endmodule

// File: tb/tb_apb_csr_completer.sv
// Scoreboard bench for apb_csr_completer; expects 3 wait states when APB_CSR_WAIT_EN is defined.
module tb_apb_csr_completer;
    import apb_csr_pkg::*;

`ifdef APB_CSR_WAIT_EN
    localparam int EXP_WAIT = 3;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_rd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [511:0]   reg_q;
    logic [511:0]   hw_rd;
    logic [15:0]    wr_pulse;

    apb_csr_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_csr_completer #(
        .ADDR_W      (12),
        .DATA_W      (32),
        .NUM_REGS    (16),
        .RO_MASK     (16'h0004),
        .RST_VAL     (32'h0),
        .WAIT_STATES (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .apb      (bus),
        .reg_q    (reg_q),
        .hw_rd    (hw_rd),
        .wr_pulse (wr_pulse)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] m_regs [16];
    logic [15:0] ro_m = 16'h0004;
    logic [31:0] obs_rd;
    logic        obs_err;
    int          obs_waits;
    bit          obs_tmo;

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t predict(logic [11:0] a, logic w, logic [3:0] s, logic [31:0] d);
        exp_t e;
        int   idx;
        idx     = int'(a[11:2]);
        e.err   = (a[1:0] != 2'b00) || (idx >= 16) || (w && ro_m[idx]);
        e.rdata = '0;
        e.is_rd = !w;
        if (!e.err) begin
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                e.rdata = ro_m[idx] ? hw_rd[idx*32 +: 32] : m_regs[idx];
            end
        end
        return e;
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = (ro_m[i]) ? 32'h0 : m_regs[i];
        return f;
    endfunction

    // Caller is at posedge+1; returns at posedge+1 after the completing edge.
    task automatic do_op(input logic [11:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        exp_q.push_back(predict(a, w, s, d));
        bus.paddr = a; bus.pwrite = w; bus.pstrb = s; bus.pwdata = d;
        bus.psel = 1'b1; bus.penable = 1'b0;
        @(posedge clk); #1 bus.penable = 1'b1;
        obs_waits = 0; obs_tmo = 1'b1; obs_rd = '0; obs_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.pready) begin
                obs_rd = bus.prdata; obs_err = bus.pslverr; obs_tmo = 1'b0;
                break;
            end
            obs_waits++;
        end
        @(posedge clk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pstrb = '0; bus.pwdata = '0;
        for (int i = 0; i < 16; i++) begin
            hw_rd[i*32 +: 32] = 32'h1111_0000 + i;
            m_regs[i] = 32'h0;
        end
        hw_rd[2*32 +: 32] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.pready !== 1'b0 || bus.pslverr !== 1'b0 || bus.prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus actual pready=%b pslverr=%b prdata=%h required 0/0/0",
                     bus.pready, bus.pslverr, bus.prdata);
        end
        checks++;
        if (reg_q !== '0 || wr_pulse !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs actual reg_q=%h wr_pulse=%h required 0", reg_q, wr_pulse);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_reset_val();
        exp_t e;
        do_op(12'h000, 1'b0, 4'hF, 32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_rd !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("FAIL rd0 actual prdata=%h err=%b tmo=%b required prdata=%h err=%b",
                     obs_rd, obs_err, obs_tmo, e.rdata, e.err);
        end
        checks++;
        if (obs_waits !== EXP_WAIT) begin
            errors++;
            $display("FAIL rd0_waits actual=%0d required=%0d", obs_waits, EXP_WAIT);
        end
    endtask

    task automatic test_strobe_write();
        exp_t e;
        do_op(12'h004, 1'b1, 4'b0101, 32'hA5A5_1234);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_err !== e.err) begin
            errors++;
            $display("FAIL wr1_err actual=%b tmo=%b required=%b", obs_err, obs_tmo, e.err);
        end
        checks++;
        if (wr_pulse !== 16'h0002) begin
            errors++;
            $display("FAIL wr1_pulse actual=%h required=%h", wr_pulse, 16'h0002);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_pulse !== 16'h0) begin
            errors++;
            $display("FAIL wr1_pulse_len actual=%h required=0", wr_pulse);
        end
        checks++;
        if (reg_q[63:32] !== 32'h00A5_0034) begin
            errors++;
            $display("FAIL wr1_regq actual=%h required=%h", reg_q[63:32], 32'h00A5_0034);
        end
        do_op(12'h004, 1'b0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_rd !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("FAIL rd1 actual prdata=%h err=%b required prdata=%h err=%b",
                     obs_rd, obs_err, e.rdata, e.err);
        end
        // pstrb=0 write: legal, no change, no pulse
        do_op(12'h00C, 1'b1, 4'h0, 32'hFFFF_FFFF);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_err !== e.err || wr_pulse !== 16'h0 || reg_q !== model_flat()) begin
            errors++;
            $display("FAIL wr_nostrb actual err=%b pulse=%h reg3=%h required err=%b pulse=0 reg3=%h",
                     obs_err, wr_pulse, reg_q[127:96], e.err, m_regs[3]);
        end
    endtask

    task automatic test_read_only();
        exp_t e;
        do_op(12'h008, 1'b0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_rd !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("FAIL ro_rd actual prdata=%h err=%b required prdata=%h err=%b",
                     obs_rd, obs_err, e.rdata, e.err);
        end
        do_op(12'h008, 1'b1, 4'hF, 32'h1234_5678);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_err !== e.err || obs_rd !== e.rdata || wr_pulse !== 16'h0) begin
            errors++;
            $display("FAIL ro_wr actual err=%b prdata=%h pulse=%h required err=%b prdata=0 pulse=0",
                     obs_err, obs_rd, wr_pulse, e.err);
        end
    endtask

    task automatic test_bad_access();
        exp_t e;
        logic [11:0] addrs [4] = '{12'h040, 12'h040, 12'h006, 12'h006};
        for (int k = 0; k < 4; k++) begin
            do_op(addrs[k], k[0], 4'hF, 32'hCAFE_F00D);
            e = exp_q.pop_front();
            checks++;
            if (obs_tmo || obs_err !== e.err || obs_rd !== e.rdata || wr_pulse !== 16'h0) begin
                errors++;
                $display("FAIL bad_acc[%0d] actual err=%b prdata=%h pulse=%h required err=%b prdata=%h",
                         k, obs_err, obs_rd, wr_pulse, e.err, e.rdata);
            end
        end
        checks++;
        if (reg_q !== model_flat()) begin
            errors++;
            $display("FAIL bad_acc_regq actual=%h required=%h", reg_q, model_flat());
        end
    endtask

    task automatic test_idle_penable();
        bit seen;
        seen = 1'b0;
        bus.paddr = 12'h000; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.pready !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_penable actual pready=1 required pready=0");
        end
        @(posedge clk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bus.paddr = 12'h004; bus.pwrite = 1'b1; bus.pstrb = 4'hF; bus.pwdata = 32'hFFFF_FFFF;
        bus.psel = 1'b1; bus.penable = 1'b0;
        @(posedge clk); #1 bus.penable = 1'b1;
`ifdef APB_CSR_WAIT_EN
        @(posedge clk); #1;
`endif
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pready !== 1'b0) begin
            errors++;
            $display("FAIL abort_pready actual=%b required=0", bus.pready);
        end
        @(posedge clk); #1;
        checks++;
        if (wr_pulse !== 16'h0 || reg_q !== model_flat()) begin
            errors++;
            $display("FAIL abort_nowrite actual pulse=%h reg1=%h required pulse=0 reg1=%h",
                     wr_pulse, reg_q[63:32], m_regs[1]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   t0;
        t0 = cyc;
        do_op(12'h010, 1'b1, 4'hF, 32'h5A5A_C3C3);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_err !== e.err) begin
            errors++;
            $display("FAIL b2b_wr actual err=%b tmo=%b required=%b", obs_err, obs_tmo, e.err);
        end
        do_op(12'h010, 1'b0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_rd !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("FAIL b2b_rd4 actual prdata=%h err=%b required prdata=%h err=%b",
                     obs_rd, obs_err, e.rdata, e.err);
        end
        do_op(12'h008, 1'b0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_rd !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("FAIL b2b_rd2 actual prdata=%h err=%b required prdata=%h err=%b",
                     obs_rd, obs_err, e.rdata, e.err);
        end
        checks++;
        if (cyc - t0 !== 3 * (2 + EXP_WAIT)) begin
            errors++;
            $display("FAIL b2b_cycles actual=%0d required=%0d", cyc - t0, 3 * (2 + EXP_WAIT));
        end
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        bus.paddr = 12'h014; bus.pwrite = 1'b1; bus.pstrb = 4'hF; bus.pwdata = 32'h7777_7777;
        bus.psel = 1'b1; bus.penable = 1'b0;
        @(posedge clk); #1 bus.penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        checks++;
        if (reg_q !== model_flat() || bus.pready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid actual reg_q=%h pready=%b required reg_q=0 pready=0", reg_q, bus.pready);
        end
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(12'h004, 1'b0, 4'h0, 32'h0);
        e = exp_q.pop_front();
        checks++;
        if (obs_tmo || obs_rd !== e.rdata || obs_err !== e.err) begin
            errors++;
            $display("FAIL rst_mid_rd actual prdata=%h err=%b required prdata=%h err=%b",
                     obs_rd, obs_err, e.rdata, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_read_reset_val();
        test_strobe_write();
        test_read_only();
        test_bad_access();
        test_idle_penable();
        test_abort();
        test_back_to_back();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
